load_scoreboard: RTL and testbench

Tracks in-flight loads issued to the variable-latency data memory and raises a decode-stage stall while any source register of the decoding instruction is still owed by an outstanding load. The hazard detection unit holds the pipeline for load-use hazards on one-cycle memory. This block covers the other end of that relationship: loads that have left EX but whose data has not yet returned. Loads enter an in-order queue at MEM issue and retire in order on memory response. Its stall output is ORed with the hazard-detection stall at the PC / IF-ID write enables.

---
 rtl/load_scoreboard_if.sv | 28 ++
 rtl/load_scoreboard.sv | 89 ++++++++
 tb/tb_load_scoreboard.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/load_scoreboard_if.sv
// Decode/MEM-side signal bundle of the load scoreboard.
// The slave modport is the scoreboard; the master modport is the pipeline driving it.
interface load_scoreboard_if #(
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          issue_i;
   logic [4:0]    issue_rd_i;
   logic          resp_i;
   logic [4:0]    rs_i;
   logic [4:0]    rt_i;
   logic          stall_o;
   logic          full_o;
   logic [4:0]    wb_rd_o;
   logic [CW-1:0] count_o;
   logic          err_o;

   modport slave (
      input  issue_i, issue_rd_i, resp_i, rs_i, rt_i,
      output stall_o, full_o, wb_rd_o, count_o, err_o
   );

   modport master (
      output issue_i, issue_rd_i, resp_i, rs_i, rt_i,
      input  stall_o, full_o, wb_rd_o, count_o, err_o
   );
endinterface

// File: rtl/load_scoreboard.sv
// In-order queue of loads in flight to variable-latency memory; stalls decode while
// a source register is still owed by an outstanding load.
module load_scoreboard #(
   parameter int DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   load_scoreboard_if.slave sb
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   logic [4:0]       rd_q [DEPTH];
   logic [4:0]       rd_d [DEPTH];
   logic [DEPTH-1:0] vld_q, vld_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             err_q, err_d;

   logic full, empty, deq, accept, bad, stall;

   always_comb begin
      full   = (count_q == CW'(DEPTH));
      empty  = (count_q == '0);
      deq    = sb.resp_i && !empty;
      // At full a same-cycle retire frees the slot the new load lands in.
      accept = sb.issue_i && (!full || sb.resp_i);
      bad    = (sb.resp_i && empty) || (sb.issue_i && full && !sb.resp_i);

      rd_d     = rd_q;
      vld_d    = vld_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      err_d    = err_q | bad;

      // Retire before enqueue so a full-queue swap on the same slot ends up valid.
      if (deq) begin
         vld_d[rd_ptr_q] = 1'b0;
         rd_ptr_d        = rd_ptr_q + PW'(1);
      end
      if (accept) begin
         rd_d[wr_ptr_q]  = sb.issue_rd_i;
         vld_d[wr_ptr_q] = 1'b1;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end

      case ({accept, deq})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Register 0 is never busy, so a zero operand never matches.
   always_comb begin
      stall = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (vld_q[i] && (((sb.rs_i != 5'd0) && (rd_q[i] == sb.rs_i)) ||
                          ((sb.rt_i != 5'd0) && (rd_q[i] == sb.rt_i))))
            stall = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         rd_q     <= '{default: '0};
         vld_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         rd_q     <= rd_d;
         vld_q    <= vld_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         err_q    <= err_d;
      end
   end

   assign sb.stall_o = stall;
   assign sb.full_o  = full;
   assign sb.wb_rd_o = rd_q[rd_ptr_q];
   assign sb.count_o = count_q;
   assign sb.err_o   = err_q;
endmodule

// File: tb/tb_load_scoreboard.sv
// Directed bench for load_scoreboard: queue-based reference model checked every
// cycle, plus literal expectations taken from hand-worked scenarios.
module tb_load_scoreboard;
   localparam int DEPTH = 4;

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;
   bit   chk_en;

   load_scoreboard_if #(.DEPTH(DEPTH)) sb ();

   load_scoreboard #(.DEPTH(DEPTH)) dut (
      .clk_i (clk),
      .rst_i (rst_n),
      .sb    (sb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: an ordered list of owed destination registers.
   int q[$];
   bit m_err;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         m_err <= 1'b0;
      end else begin
         bit was_full;
         was_full = (q.size() == DEPTH);
         if (sb.resp_i) begin
            if (q.size() > 0) void'(q.pop_front());
            else m_err <= 1'b1;
         end
         if (sb.issue_i) begin
            if (!was_full || sb.resp_i) q.push_back(int'(sb.issue_rd_i));
            else m_err <= 1'b1;
         end
      end
   end

   function automatic bit model_stall(int rs, int rt);
      foreach (q[i]) begin
         if ((rs != 0 && q[i] == rs) || (rt != 0 && q[i] == rt)) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic chk(string name, int act, int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_stall", int'(sb.stall_o), int'(model_stall(int'(sb.rs_i), int'(sb.rt_i))));
         chk("m_count", int'(sb.count_o), q.size());
         chk("m_full",  int'(sb.full_o),  int'(q.size() == DEPTH));
         chk("m_err",   int'(sb.err_o),   int'(m_err));
         if (q.size() > 0) chk("m_wb_rd", int'(sb.wb_rd_o), q[0]);
      end
   end

   // One cycle: advance past the edge, apply inputs, settle at mid-cycle.
   task automatic cyc(bit iss, int rd, bit rsp, int rs, int rt);
      @(posedge clk);
      #1;
      sb.issue_i    = iss;
      sb.issue_rd_i = 5'(rd);
      sb.resp_i     = rsp;
      sb.rs_i       = 5'(rs);
      sb.rt_i       = 5'(rt);
      @(negedge clk);
      #1;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      chk_en = 1'b0;
      rst_n = 1'b0;
      sb.issue_i = 1'b0; sb.issue_rd_i = '0; sb.resp_i = 1'b0;
      sb.rs_i = '0; sb.rt_i = '0;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_count", int'(sb.count_o), 0);
      chk("rst_stall", int'(sb.stall_o), 0);
      chk("rst_full",  int'(sb.full_o),  0);
      chk("rst_err",   int'(sb.err_o),   0);
      chk("rst_wb_rd", int'(sb.wb_rd_o), 0);
      rst_n = 1'b1;
      chk_en = 1'b1;

      // Single load
      cyc(1, 8, 0, 8, 0);
      chk("single_c0_stall", int'(sb.stall_o), 0);
      cyc(0, 0, 0, 8, 0);
      chk("single_c1_stall", int'(sb.stall_o), 1);
      chk("single_c1_count", int'(sb.count_o), 1);
      cyc(0, 0, 0, 8, 0);
      cyc(0, 0, 1, 8, 0);
      chk("single_c3_wb", int'(sb.wb_rd_o), 8);
      chk("single_c3_stall", int'(sb.stall_o), 1);
      cyc(0, 0, 0, 8, 0);
      chk("single_c4_stall", int'(sb.stall_o), 0);
      chk("single_c4_count", int'(sb.count_o), 0);

      // Register 0
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      chk("r0_stall", int'(sb.stall_o), 0);
      chk("r0_count", int'(sb.count_o), 1);
      cyc(0, 0, 1, 0, 0);
      chk("r0_wb", int'(sb.wb_rd_o), 0);
      cyc(0, 0, 0, 0, 0);
      chk("r0_count_after", int'(sb.count_o), 0);

      // Fill and overflow
      for (int k = 1; k <= 4; k++) cyc(1, k, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      chk("fill_full", int'(sb.full_o), 1);
      chk("fill_count", int'(sb.count_o), 4);
      chk("fill_err", int'(sb.err_o), 0);
      cyc(1, 5, 0, 0, 0);
      cyc(0, 0, 0, 5, 0);
      chk("ovf_err", int'(sb.err_o), 1);
      chk("ovf_count", int'(sb.count_o), 4);
      chk("ovf_nostall", int'(sb.stall_o), 0);
      cyc(1, 5, 1, 0, 0);
      chk("swap_wb", int'(sb.wb_rd_o), 1);
      cyc(0, 0, 0, 5, 0);
      chk("swap_count", int'(sb.count_o), 4);
      chk("swap_stall", int'(sb.stall_o), 1);
      for (int k = 2; k <= 5; k++) begin
         cyc(0, 0, 1, 0, 0);
         chk("drain_wb", int'(sb.wb_rd_o), k);
      end
      cyc(0, 0, 0, 0, 0);
      chk("drain_count", int'(sb.count_o), 0);

      // Duplicate destinations across the pointer wrap
      cyc(1, 10, 0, 0, 0);
      for (int k = 11; k <= 15; k++) cyc(1, k, 1, 0, 0);
      cyc(0, 0, 1, 0, 0);
      cyc(1, 7, 0, 0, 7);
      cyc(1, 7, 0, 0, 7);
      cyc(0, 0, 1, 0, 7);
      chk("dup_before", int'(sb.stall_o), 1);
      cyc(0, 0, 1, 0, 7);
      chk("dup_one_left", int'(sb.stall_o), 1);
      cyc(0, 0, 0, 0, 7);
      chk("dup_cleared", int'(sb.stall_o), 0);
      chk("dup_count", int'(sb.count_o), 0);

      // Asynchronous reset mid-cycle with three loads outstanding
      cyc(1, 20, 0, 0, 0);
      cyc(1, 21, 0, 0, 0);
      cyc(1, 22, 0, 0, 0);
      cyc(0, 0, 0, 21, 0);
      chk("ar_pre_stall", int'(sb.stall_o), 1);
      chk("ar_pre_count", int'(sb.count_o), 3);
      #1;
      rst_n = 1'b0;
      #1;
      chk("ar_stall", int'(sb.stall_o), 0);
      chk("ar_count", int'(sb.count_o), 0);
      chk("ar_full",  int'(sb.full_o),  0);
      chk("ar_err",   int'(sb.err_o),   0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Spurious response on an empty queue alongside an issue
      cyc(1, 9, 1, 0, 0);
      chk("spur_err_same", int'(sb.err_o), 0);
      cyc(0, 0, 0, 9, 0);
      chk("spur_err", int'(sb.err_o), 1);
      chk("spur_count", int'(sb.count_o), 1);
      chk("spur_stall", int'(sb.stall_o), 1);
      cyc(0, 0, 1, 9, 0);
      chk("spur_wb", int'(sb.wb_rd_o), 9);
      cyc(0, 0, 0, 9, 0);
      chk("spur_drained", int'(sb.stall_o), 0);
      cyc(0, 0, 0, 0, 0);

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
